// File: rtl/synth_pkg.sv
// Shared voice-path definitions: counter width default, channel-select width helper, channel state.
package synth_pkg;

    localparam int CNT_W_DEF = 16;

    function automatic int ch_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/tone_divider_bank_if.sv
// Divide-value load port: valid/ready handshake carrying target channel and new half-period.
interface tone_divider_bank_if #(
    parameter int CNT_W = 16,
    parameter int CH_W  = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [CH_W-1:0]  load_ch;
    logic [CNT_W-1:0] load_div;

    modport master (output load_valid, load_ch, load_div, input  load_ready);
    modport slave  (input  load_valid, load_ch, load_div, output load_ready);
endinterface

// File: rtl/tone_divider_channel.sv
// One tone channel: half-period counter, square-wave/tick outputs, shadowed divide value.
// Outputs registered; a new divide value waits in the shadow until a half-period boundary or idle.
module tone_divider_channel
    import synth_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load_we,
    input  logic [CNT_W-1:0] load_div,
    output logic             pending,
    output logic             tone,
    output logic             tick
);

    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] shadow_div;
    logic [CNT_W-1:0] count;
    ch_state_t        state;

    logic             live;
    logic             counting;
    logic             terminal;
    logic             apply;
    logic [CNT_W-1:0] next_div;
    logic             next_live;

    // The first RUN edge after IDLE only arms the counter, so a half-period is always div edges long.
    always_comb begin
        live      = enable && (active_div != '0);
        counting  = (state == RUN) && live;
        terminal  = counting && (count == active_div - CNT_W'(1));
        apply     = pending && (terminal || !counting);
        next_div  = apply ? shadow_div : active_div;
        next_live = enable && (next_div != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_div <= '0;
            shadow_div <= '0;
            pending    <= 1'b0;
            count      <= '0;
            tone       <= 1'b0;
            tick       <= 1'b0;
            state      <= IDLE;
        end else begin
            if (load_we) begin
                shadow_div <= load_div;
                pending    <= 1'b1;
            end else if (apply) begin
                pending    <= 1'b0;
            end
            if (apply)
                active_div <= shadow_div;

            if (terminal) begin
                count <= '0;
                if (next_live) begin
                    tone  <= ~tone;
                    tick  <= 1'b1;
                    state <= RUN;
                end else begin
                    tone  <= 1'b0;
                    tick  <= 1'b0;
                    state <= IDLE;
                end
            end else if (counting) begin
                count <= count + CNT_W'(1);
                tick  <= 1'b0;
            end else begin
                count <= '0;
                tone  <= 1'b0;
                tick  <= 1'b0;
                state <= next_live ? RUN : IDLE;
            end
        end
    end

endmodule

// File: rtl/tone_divider_bank.sv
// Bank of independent tone channels with a shared load port; loads to missing channels are dropped.
// load_ready is combinational from load_ch and low while that channel holds an unapplied value.
module tone_divider_bank
    import synth_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int CH_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    tone_divider_bank_if.slave  load,
    input  logic [CHANNELS-1:0] ch_enable,
    output logic [CHANNELS-1:0] tone_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] load_we;

    always_comb begin
        load.load_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load.load_ch == CH_W'(i))
                load.load_ready = !pending[i];
        end
    end

    always_comb begin
        load_we = '0;
        for (int i = 0; i < CHANNELS; i++)
            load_we[i] = load.load_valid && load.load_ready && (load.load_ch == CH_W'(i));
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        tone_divider_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .enable   (ch_enable[g]),
            .load_we  (load_we[g]),
            .load_div (load.load_div),
            .pending  (pending[g]),
            .tone     (tone_out[g]),
            .tick     (tick[g])
        );
    end

endmodule
